// File: rtl/mgpu_pkg.sv
// Shared widths, vertex layout and sequencer states for the vertex transform path.
// Coordinates are Q1.10.5 and angles are Q1.2.13, both carried as 16-bit words.
package mgpu_pkg;
  localparam int COORD_W = 16;
  localparam int ANGLE_W = 16;
  localparam int NUM_VTX = 4;
  localparam int VTX_W   = 3 * COORD_W;
  localparam int SCR_W   = 2 * COORD_W;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_PUB} state_e;

  // Bit offset of vertex idx inside vtx_flat; each slot holds {X,Y,Z}.
  function automatic int vtx_base(input logic [1:0] idx);
    return VTX_W * int'(idx);
  endfunction
endpackage

// File: rtl/xf_timeout_cnt.sv
// Per-vertex watchdog: counts enabled cycles since the last clear and saturates.
// expire_o is combinational and marks the last enabled cycle before TIMEOUT_CYC is reached.
module xf_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && cnt_q <= LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q >= LAST);
endmodule

// File: rtl/vertex_xform_sequencer.sv
// Snapshots the pose on frame_start, walks the four vertices through the shared transform
// unit one request at a time, and publishes all screen coordinates together (frame_done at t+10).
module vertex_xform_sequencer
  import mgpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                       fclk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       clr_flags,
  input  logic [COORD_W-1:0]         Xc,
  input  logic [COORD_W-1:0]         Yc,
  input  logic [COORD_W-1:0]         Zc,
  input  logic [NUM_VTX*VTX_W-1:0]   vtx_flat,
  input  logic [3*ANGLE_W-1:0]       angle_flat,
  output logic                       xf_req_valid,
  input  logic                       xf_req_ready,
  output logic [COORD_W-1:0]         xf_vx,
  output logic [COORD_W-1:0]         xf_vy,
  output logic [COORD_W-1:0]         xf_vz,
  output logic [COORD_W-1:0]         xf_cx,
  output logic [COORD_W-1:0]         xf_cy,
  output logic [COORD_W-1:0]         xf_cz,
  output logic [ANGLE_W-1:0]         xf_ax,
  output logic [ANGLE_W-1:0]         xf_ay,
  output logic [ANGLE_W-1:0]         xf_az,
  output logic [1:0]                 xf_idx,
  input  logic                       xf_rsp_valid,
  input  logic [COORD_W-1:0]         xf_rsp_sx,
  input  logic [COORD_W-1:0]         xf_rsp_sy,
  output logic [NUM_VTX*SCR_W-1:0]   scr_flat,
  output logic                       scr_valid,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       err_overrun,
  output logic                       err_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e                          state_q;
  logic [1:0]                      idx_q;
  logic [NUM_VTX*VTX_W-1:0]        vtx_q;
  logic [COORD_W-1:0]              cx_q, cy_q, cz_q;
  logic [3*ANGLE_W-1:0]            ang_q;
  logic [NUM_VTX-1:0][SCR_W-1:0]   shadow_q;
  logic [NUM_VTX-1:0][SCR_W-1:0]   scr_q;
  logic                            scr_vld_q, done_q, ovr_q, tmo_q;
  logic                            last_vtx, rsp_take, cnt_clr, cnt_en, expire;

  assign last_vtx = (idx_q == 2'(NUM_VTX - 1));
  assign rsp_take = (state_q == ST_WAIT) && xf_rsp_valid;
  // Counter restarts on every entry to REQ: frame launch or a non-final response.
  assign cnt_clr  = ((state_q == ST_IDLE) && frame_start) || (rsp_take && !last_vtx);
  assign cnt_en   = (state_q == ST_REQ) || (state_q == ST_WAIT);

  xf_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_tmo (
    .clk     (fclk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .expire_o(expire)
  );

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      vtx_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      cz_q      <= '0;
      ang_q     <= '0;
      shadow_q  <= '0;
      scr_q     <= '0;
      scr_vld_q <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Flag sets below come later so a same-cycle error beats the clear.
      if (clr_flags) begin
        ovr_q <= 1'b0;
        tmo_q <= 1'b0;
      end
      if (frame_start && state_q != ST_IDLE) ovr_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            vtx_q   <= vtx_flat;
            cx_q    <= Xc;
            cy_q    <= Yc;
            cz_q    <= Zc;
            ang_q   <= angle_flat;
            idx_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (xf_req_ready) begin
            state_q <= ST_WAIT;
          end else if (expire) begin
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (xf_rsp_valid) begin
            shadow_q[idx_q] <= {xf_rsp_sx, xf_rsp_sy};
            if (last_vtx) begin
              state_q <= ST_PUB;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= ST_REQ;
            end
          end else if (expire) begin
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          scr_q     <= shadow_q;
          scr_vld_q <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign xf_req_valid = (state_q == ST_REQ);
  assign busy         = (state_q != ST_IDLE);
  assign xf_idx       = idx_q;
  assign xf_vx        = vtx_q[vtx_base(idx_q) + 2*COORD_W +: COORD_W];
  assign xf_vy        = vtx_q[vtx_base(idx_q) +   COORD_W +: COORD_W];
  assign xf_vz        = vtx_q[vtx_base(idx_q)             +: COORD_W];
  assign xf_cx        = cx_q;
  assign xf_cy        = cy_q;
  assign xf_cz        = cz_q;
  assign xf_ax        = ang_q[2*ANGLE_W +: ANGLE_W];
  assign xf_ay        = ang_q[ANGLE_W   +: ANGLE_W];
  assign xf_az        = ang_q[0         +: ANGLE_W];
  assign scr_flat     = scr_q;
  assign scr_valid    = scr_vld_q;
  assign frame_done   = done_q;
  assign err_overrun  = ovr_q;
  assign err_timeout  = tmo_q;
endmodule
